data_mem_wait: RTL and testbench

//  Parametrised MEM-stage data memory: byte-addressed, little-endian store with byte/half/word access.

---
 rtl/data_mem_wait.sv | 180 ++++++++++++++++++
 tb/tb_data_mem_wait.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_wait.sv
// MEM-stage data memory: byte-addressed little-endian storage behind a valid/ready handshake
// with programmable wait states. Define MEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses.
module data_mem_wait #(
  parameter int DEPTH_BYTES = 2048,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        stall,
  output logic        err
);

  localparam int IW    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam logic [IW-1:0] BASE_IDX = IW'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_e;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = 4'b0011 << lane;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   store_lanes = {4{wd[7:0]}};
      2'b01:   store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   load_extract = {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   load_extract = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lane[0];
      default: is_misaligned = |lane;
    endcase
  endfunction

  function automatic logic [IW-1:0] align_idx(input logic [1:0] size, input logic [IW-1:0] idx);
    case (size)
      2'b00:   align_idx = idx;
      2'b01:   align_idx = {idx[IW-1:1], 1'b0};
      default: align_idx = {idx[IW-1:2], 2'b00};
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            we_q, sgn_q;
  logic [1:0]      size_q;
  logic [IW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem_q [WORDS];

  logic            in_idle, accept, commit, misal, wr_en;
  logic            op_we, op_sgn;
  logic [1:0]      op_size;
  logic [IW-1:0]   raw_idx, op_idx, eff_idx;
  logic [31:0]     op_wdata, rd_word, wr_data;
  logic [3:0]      wr_be;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:IW];
  assign raw_idx        = req_addr[IW-1:0] - BASE_IDX;

  assign in_idle   = (state_q == S_IDLE);
  assign req_ready = in_idle;
  assign rsp_valid = (state_q == S_RESP);
  assign stall     = (in_idle & req_valid) | (state_q == S_WAIT);
  assign rsp_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        accept  = 1'b1;
        cnt_d   = 4'(WAIT_STATES);
        state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access completes on the accept edge, so take fields straight from the bus.
  assign op_we    = in_idle ? req_we     : we_q;
  assign op_size  = in_idle ? req_size   : size_q;
  assign op_sgn   = in_idle ? req_signed : sgn_q;
  assign op_idx   = in_idle ? raw_idx    : idx_q;
  assign op_wdata = in_idle ? req_wdata  : wdata_q;
  assign commit   = (state_d == S_RESP);

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;
  assign misal   = is_misaligned(op_size, op_idx[1:0]);
  assign eff_idx = op_idx;
  assign err     = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= commit & misal;
  end
`else
  assign misal   = 1'b0;
  assign eff_idx = align_idx(op_size, op_idx);
  assign err     = 1'b0;
`endif

  assign rd_word = mem_q[eff_idx[IW-1:2]];
  assign wr_en   = commit & op_we & ~misal;
  assign wr_be   = byte_en(op_size, eff_idx[1:0]);
  assign wr_data = store_lanes(op_size, op_wdata);

  always_comb begin
    rdata_d = 32'd0;
    if (commit && !op_we && !misal)
      rdata_d = load_extract(rd_word, eff_idx[1:0], op_size, op_sgn);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      sgn_q   <= req_signed;
      idx_q   <= raw_idx;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) mem_q[eff_idx[IW-1:2]][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_wait.sv
// Directed bench for data_mem_wait: one instance with no wait states, one with three.
module tb_data_mem_wait;

  logic        clk = 1'b0;
  logic        rst0_n, rst3_n;
  logic        v0, v3;
  logic        b_we, b_sgn;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata;
  logic        rdy0, rv0, st0, er0, rdy3, rv3, st3, er3;
  logic [31:0] rd0, rd3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_wait #(.DEPTH_BYTES(2048), .BASE_ADDR(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .req_valid(v0), .req_we(b_we), .req_size(b_size),
    .req_signed(b_sgn), .req_addr(b_addr), .req_wdata(b_wdata), .req_ready(rdy0),
    .rsp_valid(rv0), .rsp_rdata(rd0), .stall(st0), .err(er0));

  data_mem_wait #(.DEPTH_BYTES(2048), .BASE_ADDR(1024), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(v3), .req_we(b_we), .req_size(b_size),
    .req_signed(b_sgn), .req_addr(b_addr), .req_wdata(b_wdata), .req_ready(rdy3),
    .rsp_valid(rv3), .rsp_rdata(rd3), .stall(st3), .err(er3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic access(input bit sel, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic e);
    int n;
    @(negedge clk);
    b_we = we; b_size = size; b_sgn = sgn; b_addr = addr; b_wdata = wdata;
    if (sel) v3 = 1'b1; else v0 = 1'b1;
    #1;
    chk("acc_ready", sel ? rdy3 : rdy0, 1);
    chk("acc_stall", sel ? st3 : st0, 1);
    @(posedge clk); #1;
    v0 = 1'b0; v3 = 1'b0;
    n = 1;
    while (!(sel ? rv3 : rv0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, sel ? 4 : 1);
    rdata = sel ? rd3 : rd0;
    e     = sel ? er3 : er0;
    if (we) chk("store_rdata", rdata, 0);
    @(posedge clk); #1;
    chk("rsp_pulse", sel ? rv3 : rv0, 0);
    chk("rdata_clr", sel ? rd3 : rd0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        e;
    logic [5:0]  sst, srd, srv;
    logic        seen;

    v0 = 0; v3 = 0; b_we = 0; b_sgn = 0; b_size = 0; b_addr = 0; b_wdata = 0;
    rst0_n = 0; rst3_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", rdy0, 1); chk("rst_rsp0", rv0, 0);
    chk("rst_rdata0", rd0, 0);  chk("rst_err0", er0, 0);
    chk("rst_ready3", rdy3, 1); chk("rst_stall3", st3, 0);
    @(negedge clk); rst0_n = 1; rst3_n = 1;

    // Word store/load with no wait states
    access(0, 1, 2'b10, 0, 32'h400, 32'hDEADBEEF, r, e);
    access(0, 0, 2'b10, 0, 32'h400, 32'h0, r, e);
    chk("t1_word", r, 32'hDEADBEEF);

    // Byte lanes and extension
    access(0, 1, 2'b00, 0, 32'h402, 32'h12345680, r, e);
    access(0, 0, 2'b00, 1, 32'h402, 32'h0, r, e);
    chk("t2_byte_s", r, 32'hFFFFFF80);
    access(0, 0, 2'b00, 0, 32'h402, 32'h0, r, e);
    chk("t2_byte_u", r, 32'h00000080);
    access(0, 0, 2'b10, 0, 32'h400, 32'h0, r, e);
    chk("t2_word", r, 32'hDE80BEEF);
    access(0, 0, 2'b01, 1, 32'h402, 32'h0, r, e);
    chk("t2_half_s", r, 32'hFFFFDE80);
    access(0, 0, 2'b01, 1, 32'h400, 32'h0, r, e);
    chk("t2_half_s_lo", r, 32'hFFFFBEEF);
    access(0, 0, 2'b00, 0, 32'h403, 32'h0, r, e);
    chk("t2_byte3", r, 32'h000000DE);
    access(0, 0, 2'b11, 1, 32'h400, 32'h0, r, e);
    chk("t2_size_rsvd", r, 32'hDE80BEEF);

    // Address wrap above and below the mapped window
    access(0, 1, 2'b10, 0, 32'hC00, 32'h12345678, r, e);
    access(0, 0, 2'b10, 0, 32'h400, 32'h0, r, e);
    chk("t4_wrap_hi", r, 32'h12345678);
    access(0, 1, 2'b10, 0, 32'h3FC, 32'hCAFEF00D, r, e);
    access(0, 0, 2'b10, 0, 32'hBFC, 32'h0, r, e);
    chk("t4_wrap_lo", r, 32'hCAFEF00D);

    // Wait-state handshake shape with req_valid held high
    access(1, 1, 2'b10, 0, 32'h404, 32'h55667788, r, e);
    @(negedge clk);
    b_we = 0; b_size = 2'b10; b_sgn = 0; b_addr = 32'h404; v3 = 1'b1;
    #1;
    r = 32'h0;
    for (int i = 0; i < 6; i++) begin
      sst[i] = st3; srd[i] = rdy3; srv[i] = rv3;
      if (rv3) r = rd3;
      @(negedge clk); #1;
    end
    v3 = 1'b0;
    chk("t3_stall_seq", sst, 6'b101111);
    chk("t3_ready_seq", srd, 6'b100001);
    chk("t3_rsp_seq", srv, 6'b010000);
    chk("t3_rdata", r, 32'h55667788);
    repeat (6) @(posedge clk);
    #1;
    chk("t3_idle_ready", rdy3, 1);
    chk("t3_idle_rsp", rv3, 0);

    // Reset during WAIT drops the pending store
    @(negedge clk);
    b_we = 1; b_size = 2'b10; b_addr = 32'h404; b_wdata = 32'hAAAAAAAA; v3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0;
    chk("t5_in_wait", st3, 1);
    @(negedge clk);
    rst3_n = 1'b0;
    #1;
    chk("t5_rst_ready", rdy3, 1);
    chk("t5_rst_stall", st3, 0);
    seen = rv3;
    @(negedge clk);
    rst3_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | rv3;
    end
    chk("t5_no_rsp", seen, 0);
    access(1, 0, 2'b10, 0, 32'h404, 32'h0, r, e);
    chk("t5_old_data", r, 32'h55667788);

    // Misaligned half store and word load
    access(0, 1, 2'b10, 0, 32'h400, 32'h11223344, r, e);
    access(0, 1, 2'b01, 0, 32'h401, 32'h0000BEEF, r, e);
`ifdef MEM_ALIGN_CHECK_EN
    chk("t6_st_err", e, 1);
    access(0, 0, 2'b10, 0, 32'h400, 32'h0, r, e);
    chk("t6_unchanged", r, 32'h11223344);
    chk("t6_ld_ok_err", e, 0);
    access(0, 0, 2'b10, 0, 32'h402, 32'h0, r, e);
    chk("t6_misld_rdata", r, 32'h0);
    chk("t6_misld_err", e, 1);
`else
    chk("t6_st_err", e, 0);
    access(0, 0, 2'b10, 0, 32'h400, 32'h0, r, e);
    chk("t6_forced", r, 32'h1122BEEF);
    access(0, 0, 2'b10, 0, 32'h402, 32'h0, r, e);
    chk("t6_misld_rdata", r, 32'h1122BEEF);
    chk("t6_misld_err", e, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
